// File: rtl/reg_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// reg_scoreboard_pkg
// Core-wide constants shared by the register scoreboard and the decode logic.
//   REG_W    : architectural register index width
//   NREGS    : number of architectural registers (r0 is hardwired zero)
//   LAT_W    : width of the per-register forwarding latency countdown
//   LAT_*    : issue latency per producer class (cycles until forwardable)
//   LW, BEQ  : primary opcode values used by decode alongside the latencies
// -----------------------------------------------------------------------------
package reg_scoreboard_pkg;

  localparam int REG_W = 5;
  localparam int NREGS = 32;
  localparam int LAT_W = 3;

  // A producer with latency 0 can be forwarded to the very next instruction.
  localparam logic [LAT_W-1:0] LAT_ALU = 3'd0;
  localparam logic [LAT_W-1:0] LAT_LW  = 3'd1;
  localparam logic [LAT_W-1:0] LAT_MUL = 3'd4;
  localparam logic [LAT_W-1:0] LAT_DIV = 3'd7;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] BEQ = 6'b000100;

endpackage

// File: rtl/reg_scoreboard_entry.sv
// -----------------------------------------------------------------------------
// sb_entry
// One scoreboard slot: a pending bit plus a saturating countdown of the cycles
// left until the producing instruction's result can be forwarded.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   set        : load pending=1 and count=set_count (takes priority over clear)
//   set_count  : latency loaded on set
//   clear      : drop the entry (writeback or flush)
//   dec        : allow the countdown to advance this cycle
//   pending    : entry is in flight
//   ready      : entry is in flight and its result is forwardable
// -----------------------------------------------------------------------------
module sb_entry
  import reg_scoreboard_pkg::*;
#(
  parameter int LAT_W = reg_scoreboard_pkg::LAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic [LAT_W-1:0] set_count,
  input  logic             clear,
  input  logic             dec,
  output logic             pending,
  output logic             ready
);

  logic [LAT_W-1:0] count;

  // Set beats clear so that a forced same-cycle issue/writeback keeps the
  // newer producer. The countdown stops at zero rather than wrapping, so a
  // ready entry stays ready until it is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      count   <= '0;
    end else if (set) begin
      pending <= 1'b1;
      count   <= set_count;
    end else if (clear) begin
      pending <= 1'b0;
      count   <= '0;
    end else if (dec && pending && (count != '0)) begin
      count <= count - LAT_W'(1);
    end
  end

  assign ready = pending && (count == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Tracks in-flight register writes (including multi-cycle LW and MULT/DIV
// producers) beside the ID stage and derives the ID hold signals from them.
// Ports:
//   clk, rst         : clock and synchronous active-high reset
//   id_rs, id_rt     : ID-stage source registers
//   id_rt_is_source  : rt is actually read by the ID instruction
//   issue_valid      : ID instruction writes a register and wants to issue
//   issue_dst        : destination of the issuing instruction
//   issue_lat        : cycles until that result is forwardable
//   wb_valid, wb_dst : register write completing in WB
//   flush            : cancel the instruction issued in the previous cycle
//   stall            : ID must hold (combinational)
//   pc_write         : ~stall
//   if_id_write_en   : ~stall
//   pending_mask     : registered per-register pending bits (bit 0 always 0)
// Optional build macro SCOREBOARD_STATS_EN adds:
//   stall_cycles     : saturating count of stalled cycles
//   waw_stalls       : saturating count of cycles stalled only by WAW
// -----------------------------------------------------------------------------
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREGS = reg_scoreboard_pkg::NREGS,
  parameter int LAT_W = reg_scoreboard_pkg::LAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_is_source,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_dst,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_dst,
  input  logic             flush,
  output logic             stall,
  output logic             pc_write,
  output logic             if_id_write_en,
  output logic [NREGS-1:0] pending_mask
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [15:0]      waw_stalls
`endif
);

  logic [NREGS-1:0] pend_vec;
  logic [NREGS-1:0] ready_vec;
  logic             src_stall;
  logic             waw_stall;
  logic             accept;
  logic             last_valid;
  logic [REG_W-1:0] last_dst;

  // r0 has no slot, so it can never look pending or busy.
  assign pend_vec[0]  = 1'b0;
  assign ready_vec[0] = 1'b0;

  generate
    for (genvar i = 1; i < NREGS; i++) begin : g_entry
      logic set_i;
      logic clr_i;

      assign set_i = accept && (issue_dst == REG_W'(i));
      // A flush only ever targets the single instruction issued last cycle.
      assign clr_i = (wb_valid && (wb_dst == REG_W'(i))) ||
                     (flush && last_valid && (last_dst == REG_W'(i)));

      sb_entry #(.LAT_W(LAT_W)) u_entry (
        .clk       (clk),
        .rst       (rst),
        .set       (set_i),
        .set_count (issue_lat),
        .clear     (clr_i),
        .dec       (1'b1),
        .pending   (pend_vec[i]),
        .ready     (ready_vec[i])
      );
    end
  endgenerate

  // A source only holds ID while its producer is not yet forwardable; a ready
  // entry is served by the bypass network.
  assign src_stall = (pend_vec[id_rs] && !ready_vec[id_rs]) ||
                     (id_rt_is_source && pend_vec[id_rt] && !ready_vec[id_rt]);

  // Any pending destination blocks a new writer, otherwise the older
  // writeback would retire the newer entry.
  assign waw_stall = issue_valid && pend_vec[issue_dst];

  assign stall          = src_stall || waw_stall;
  assign pc_write       = !stall;
  assign if_id_write_en = !stall;
  assign accept         = issue_valid && !stall && !flush;
  assign pending_mask   = pend_vec;

  // Remember what was issued on the previous edge so a taken branch can
  // cancel it; the record lives for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_valid <= 1'b0;
      last_dst   <= '0;
    end else begin
      last_valid <= accept;
      last_dst   <= issue_dst;
    end
  end

`ifdef SCOREBOARD_STATS_EN
  // Performance counters; both hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      waw_stalls   <= '0;
    end else begin
      if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (waw_stall && !src_stall && (waw_stalls != 16'hFFFF)) begin
        waw_stalls <= waw_stalls + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_scoreboard
// Directed scenarios plus a randomized run of reg_scoreboard, compared against
// a time-stamp model: each pending register remembers the cycle number at
// which its result becomes forwardable.
// -----------------------------------------------------------------------------
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_rt_is_source;
  logic        issue_valid;
  logic [4:0]  issue_dst;
  logic [2:0]  issue_lat;
  logic        wb_valid;
  logic [4:0]  wb_dst;
  logic        flush;
  logic        stall;
  logic        pc_write;
  logic        if_id_write_en;
  logic [31:0] pending_mask;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] waw_stalls;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit m_pend[32];
  int m_ready_at[32];
  int cyc = 0;
  bit m_last_v;
  int m_last_d;
  int m_stall_cnt;
  int m_waw_cnt;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rt_is_source (id_rt_is_source),
    .issue_valid     (issue_valid),
    .issue_dst       (issue_dst),
    .issue_lat       (issue_lat),
    .wb_valid        (wb_valid),
    .wb_dst          (wb_dst),
    .flush           (flush),
    .stall           (stall),
    .pc_write        (pc_write),
    .if_id_write_en  (if_id_write_en),
    .pending_mask    (pending_mask)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_cycles    (stall_cycles),
    .waw_stalls      (waw_stalls)
`endif
  );

  // A register blocks its readers until the cycle its result is forwardable.
  function automatic bit m_busy(int r);
    return (r != 0) && m_pend[r] && (cyc < m_ready_at[r]);
  endfunction

  function automatic bit m_src_stall();
    return m_busy(int'(id_rs)) || (id_rt_is_source && m_busy(int'(id_rt)));
  endfunction

  function automatic bit m_waw();
    return issue_valid && (issue_dst != 5'd0) && m_pend[int'(issue_dst)];
  endfunction

  function automatic bit m_stall();
    return m_src_stall() || m_waw();
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m;
    m = '0;
    for (int r = 1; r < 32; r++) m[r] = m_pend[r];
    return m;
  endfunction

  // Advance the model with the inputs currently applied, then one clock.
  task automatic tick();
    bit st;
    bit acc;
    st = m_stall();
    if (rst) begin
      for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
      m_last_v    = 1'b0;
      m_stall_cnt = 0;
      m_waw_cnt   = 0;
    end else begin
      acc = issue_valid && !st && !flush;
      if (st) m_stall_cnt++;
      if (m_waw() && !m_src_stall()) m_waw_cnt++;
      if (wb_valid) m_pend[int'(wb_dst)] = 1'b0;
      if (flush && m_last_v) m_pend[m_last_d] = 1'b0;
      if (acc && (issue_dst != 5'd0)) begin
        m_pend[int'(issue_dst)]     = 1'b1;
        m_ready_at[int'(issue_dst)] = cyc + 1 + int'(issue_lat);
      end
      m_last_v = acc;
      m_last_d = int'(issue_dst);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst             = 1'b0;
    id_rs           = '0;
    id_rt           = '0;
    id_rt_is_source = 1'b0;
    issue_valid     = 1'b0;
    issue_dst       = '0;
    issue_lat       = '0;
    wb_valid        = 1'b0;
    wb_dst          = '0;
    flush           = 1'b0;
  endtask

  task automatic do_issue(input logic [4:0] d, input logic [2:0] l);
    idle_inputs();
    issue_valid = 1'b1;
    issue_dst   = d;
    issue_lat   = l;
    tick();
  endtask

  task automatic do_wb(input logic [4:0] d);
    idle_inputs();
    wb_valid = 1'b1;
    wb_dst   = d;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    do_issue(5'd3, 3'd5);
    do_issue(5'd4, 3'd7);
    idle_inputs();
    rst = 1'b1;
    tick();
    idle_inputs();
    id_rs = 5'd3;
    id_rt = 5'd4;
    id_rt_is_source = 1'b1;
    #1;
    n_vec++;
    if (pending_mask !== 32'd0) begin
      n_err++;
      $display("[TB] FAIL reset_mask: got %h want %h", pending_mask, 32'd0);
    end
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_stall: got %b want 0", stall);
    end
    n_vec++;
    if (pc_write !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL reset_pc_write: got %b want 1", pc_write);
    end
    n_vec++;
    if (if_id_write_en !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL reset_if_id_write_en: got %b want 1", if_id_write_en);
    end
    tick();
  endtask

  task automatic test_load_use();
    idle_inputs();
    issue_valid = 1'b1;
    issue_dst   = 5'd5;
    issue_lat   = 3'd1;
    #1;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL lu_issue_stall: got %b want 0", stall);
    end
    tick();
    idle_inputs();
    id_rs = 5'd5;
    #1;
    n_vec++;
    if (stall !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL lu_dep_stall: got %b want 1", stall);
    end
    n_vec++;
    if (pending_mask[5] !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL lu_pending: got %b want 1", pending_mask[5]);
    end
    tick();
    #1;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL lu_forward: got %b want 0", stall);
    end
    wb_valid = 1'b1;
    wb_dst   = 5'd5;
    #1;
    n_vec++;
    if (pending_mask[5] !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL lu_wb_before_edge: got %b want 1", pending_mask[5]);
    end
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (pending_mask[5] !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL lu_wb_clear: got %b want 0", pending_mask[5]);
    end
  endtask

  task automatic test_mul_chain();
    int n;
    do_issue(5'd8, 3'd4);
    idle_inputs();
    id_rt = 5'd8;
    id_rt_is_source = 1'b0;
    #1;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL mul_rt_not_source: got %b want 0", stall);
    end
    id_rt_is_source = 1'b1;
    n = 0;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (stall !== 1'b1) break;
      n++;
      tick();
    end
    n_vec++;
    if (n != 4) begin
      n_err++;
      $display("[TB] FAIL mul_stall_len: got %0d cycles want 4", n);
    end
    do_wb(5'd8);
  endtask

  task automatic test_waw();
    do_issue(5'd9, 3'd2);
    idle_inputs();
    issue_valid = 1'b1;
    issue_dst   = 5'd9;
    issue_lat   = 3'd1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++;
      if (stall !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL waw_hold[%0d]: got %b want 1", k, stall);
      end
      tick();
    end
    wb_valid = 1'b1;
    wb_dst   = 5'd9;
    #1;
    n_vec++;
    if (stall !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL waw_wb_cycle: got %b want 1", stall);
    end
    tick();
    wb_valid = 1'b0;
    #1;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL waw_release: got %b want 0", stall);
    end
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (pending_mask[9] !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL waw_reissue: got %b want 1", pending_mask[9]);
    end
    do_wb(5'd9);
  endtask

  task automatic test_flush();
    do_issue(5'd13, 3'd0);
    idle_inputs();
    tick();
    do_issue(5'd12, 3'd3);
    idle_inputs();
    flush = 1'b1;
    #1;
    n_vec++;
    if (pending_mask[12] !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL flush_pre: got %b want 1", pending_mask[12]);
    end
    tick();
    idle_inputs();
    id_rs = 5'd12;
    #1;
    n_vec++;
    if (pending_mask[12] !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL flush_clear: got %b want 0", pending_mask[12]);
    end
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL flush_query: got %b want 0", stall);
    end
    flush = 1'b1;
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (pending_mask[13] !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL flush_no_record: got %b want 1", pending_mask[13]);
    end
    do_wb(5'd13);
  endtask

  task automatic test_reg0();
    idle_inputs();
    issue_valid = 1'b1;
    issue_dst   = 5'd0;
    issue_lat   = 3'd7;
    #1;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL r0_issue: got %b want 0", stall);
    end
    tick();
    id_rs = 5'd0;
    id_rt = 5'd0;
    id_rt_is_source = 1'b1;
    #1;
    n_vec++;
    if (pending_mask !== 32'd0) begin
      n_err++;
      $display("[TB] FAIL r0_mask: got %h want 0", pending_mask);
    end
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL r0_stall: got %b want 0", stall);
    end
    tick();
  endtask

  task automatic test_random();
    bit exp_st;
    for (int k = 0; k < 400; k++) begin
      rst             = ($urandom_range(0, 99) == 0);
      id_rs           = 5'($urandom_range(0, 7));
      id_rt           = 5'($urandom_range(0, 7));
      id_rt_is_source = 1'($urandom_range(0, 1));
      issue_valid     = 1'($urandom_range(0, 1));
      issue_dst       = 5'($urandom_range(0, 7));
      issue_lat       = 3'($urandom_range(0, 7));
      wb_valid        = ($urandom_range(0, 3) == 0);
      wb_dst          = 5'($urandom_range(0, 7));
      flush           = ($urandom_range(0, 9) == 0);
      #1;
      exp_st = m_stall();
      n_vec++;
      if (stall !== exp_st) begin
        n_err++;
        $display("[TB] FAIL rand_stall@%0d: got %b want %b", k, stall, exp_st);
      end
      n_vec++;
      if (pc_write !== !exp_st) begin
        n_err++;
        $display("[TB] FAIL rand_pc_write@%0d: got %b want %b", k, pc_write, !exp_st);
      end
      n_vec++;
      if (pending_mask !== m_mask()) begin
        n_err++;
        $display("[TB] FAIL rand_mask@%0d: got %h want %h", k, pending_mask, m_mask());
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_stats();
`ifdef SCOREBOARD_STATS_EN
    #1;
    n_vec++;
    if (stall_cycles !== 32'(m_stall_cnt)) begin
      n_err++;
      $display("[TB] FAIL stall_cycles: got %0d want %0d", stall_cycles, m_stall_cnt);
    end
    n_vec++;
    if (waw_stalls !== 16'(m_waw_cnt)) begin
      n_err++;
      $display("[TB] FAIL waw_stalls: got %0d want %0d", waw_stalls, m_waw_cnt);
    end
`endif
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_mul_chain();
    test_waw();
    test_flush();
    test_reg0();
    test_stats();
    test_random();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
